// File: rtl/fifo_pkg.sv
// Shared definitions for the 4-wide superscalar FIFO and its line packer.
//   SLOTS        - elements per FIFO line
//   slot_cnt_t   - element count within a line (0..SLOTS)
//   DEFAULT_LINE - default element width, shared with the FIFO
package fifo_pkg;

    localparam int SLOTS        = 4;
    localparam int DEFAULT_LINE = 18;

    typedef logic [2:0] slot_cnt_t;

endpackage

// File: rtl/fifo_line_packer_if.sv
// Stream-in / line-out bundle of the line packer.
//   in_valid/in_dat/in_ready - single-element producer handshake
//   flush                    - request early write of a partial line
//   full_soon                - FIFO backpressure
//   we/we_count/dat_w_1..4   - one-cycle line write towards the FIFO
//   idle                     - packer holds nothing and is not writing
// master: the environment (producer + FIFO); slave: the packer.
interface fifo_line_packer_if #(
    parameter int LINE = fifo_pkg::DEFAULT_LINE
);
    logic            in_valid;
    logic [LINE-1:0] in_dat;
    logic            in_ready;
    logic            flush;
    logic            full_soon;
    logic            we;
    logic [1:0]      we_count;
    logic [LINE-1:0] dat_w_1;
    logic [LINE-1:0] dat_w_2;
    logic [LINE-1:0] dat_w_3;
    logic [LINE-1:0] dat_w_4;
    logic            idle;

    modport master (
        output in_valid, in_dat, flush, full_soon,
        input  in_ready, we, we_count, dat_w_1, dat_w_2, dat_w_3, dat_w_4, idle
    );

    modport slave (
        input  in_valid, in_dat, flush, full_soon,
        output in_ready, we, we_count, dat_w_1, dat_w_2, dat_w_3, dat_w_4, idle
    );
endinterface

// File: rtl/fifo_line_packer_hold_timer.sv
// hold_timer: saturating age counter for the oldest held element.
//   clk, reset - clock, synchronous active-high reset
//   clr        - restart the count at 0 (has priority over en)
//   en         - advance the count by one, saturating at TIMEOUT
//   timed_out  - count has reached TIMEOUT; constant 0 when TIMEOUT == 0
module hold_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timed_out
);
    localparam int AW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT);

    logic [AW-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (clr) begin
            age_d = '0;
        end else if (en && (age_q != AGE_MAX)) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // With TIMEOUT == 0 the counter is pinned at 0 and the compare is masked.
    assign timed_out = (TIMEOUT != 0) && (age_q >= AGE_MAX);
endmodule

// File: rtl/fifo_line_packer.sv
// fifo_line_packer: packs a single-element valid/ready stream into lines of
// up to SLOTS elements and writes each line to the superscalar FIFO with one
// we pulse. Partial lines leave early on flush or when the oldest element has
// waited TIMEOUT cycles. Nothing is written while full_soon is high.
//   clk, reset - clock, synchronous active-high reset
//   bus        - fifo_line_packer_if slave (stream in, line write out, idle)
module fifo_line_packer
    import fifo_pkg::*;
#(
    parameter int LINE    = DEFAULT_LINE,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    fifo_line_packer_if.slave   bus
);
    localparam slot_cnt_t FULL_CNT = slot_cnt_t'(SLOTS);

    logic [LINE-1:0] acc_q   [SLOTS];
    logic [LINE-1:0] acc_d   [SLOTS];
    logic [LINE-1:0] dat_w_q [SLOTS];
    logic [LINE-1:0] dat_w_d [SLOTS];
    slot_cnt_t       acc_cnt_q, acc_cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic            we_q, we_d;
    logic [1:0]      we_count_q, we_count_d;

    logic            in_ready;
    logic            accept;
    logic            timed_out;
    logic            line_ready;
    logic            emit;
    logic [1:0]      wr_idx;

    // A full line stalls input only while the FIFO cannot take it; otherwise
    // the line leaves and the new element enters slot 0 on the same edge.
    assign in_ready   = (acc_cnt_q != FULL_CNT) | ~bus.full_soon;
    assign accept     = bus.in_valid & in_ready;
    assign line_ready = (acc_cnt_q == FULL_CNT) |
                        ((acc_cnt_q != '0) & (flush_pend_q | timed_out));
    assign emit       = line_ready & ~bus.full_soon;
    // Accept is impossible with acc_cnt_q == SLOTS and no emit, so 2 bits index.
    assign wr_idx     = emit ? 2'd0 : acc_cnt_q[1:0];

    hold_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_hold_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (emit | (accept & (acc_cnt_q == '0))),
        .en        (acc_cnt_q != '0),
        .timed_out (timed_out)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        acc_d      = acc_q;
        dat_w_d    = dat_w_q;
        we_count_d = we_count_q;
        we_d       = 1'b0;

        if (accept) begin
            acc_d[wr_idx] = bus.in_dat;
        end

        if (emit) begin
            we_d       = 1'b1;
            we_count_d = 2'(acc_cnt_q - 3'd1);
            for (int i = 0; i < SLOTS; i++) begin
                dat_w_d[i] = (slot_cnt_t'(i) < acc_cnt_q) ? acc_q[i] : '0;
            end
        end

        if (emit) begin
            acc_cnt_d = accept ? 3'd1 : 3'd0;
        end else begin
            acc_cnt_d = acc_cnt_q + (accept ? 3'd1 : 3'd0);
        end

        // A flush is satisfied by a line leaving on the same edge; one that
        // finds nothing held is dropped.
        flush_pend_d = ~emit & (flush_pend_q | bus.flush) & (acc_cnt_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            we_q         <= 1'b0;
            we_count_q   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                dat_w_q[i] <= '0;
            end
        end else begin
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            we_q         <= we_d;
            we_count_q   <= we_count_d;
            dat_w_q      <= dat_w_d;
        end
    end

    // NOTE: the accumulator is deliberately not reset; slots at or beyond
    // acc_cnt_q are never observed because the output load masks them to 0.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign bus.in_ready = in_ready;
    assign bus.we       = we_q;
    assign bus.we_count = we_count_q;
    assign bus.dat_w_1  = dat_w_q[0];
    assign bus.dat_w_2  = dat_w_q[1];
    assign bus.dat_w_3  = dat_w_q[2];
    assign bus.dat_w_4  = dat_w_q[3];
    assign bus.idle     = (acc_cnt_q == '0) & ~we_q;
endmodule

// File: tb/tb_fifo_line_packer.sv
// Self-checking bench for fifo_line_packer: a table of directed vectors for
// streaming and flush, plus hand-written sequences for timeout, backpressure,
// flush racing the 4th accept, and reset mid-line. A second instance with
// TIMEOUT=0 shares the stimulus to show the timeout can be disabled.
module tb_fifo_line_packer;
    localparam int LINE = 18;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    fifo_line_packer_if #(.LINE(LINE)) bus   ();
    fifo_line_packer_if #(.LINE(LINE)) bus_z ();

    fifo_line_packer #(.LINE(LINE), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    fifo_line_packer #(.LINE(LINE), .TIMEOUT(0)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_z.slave)
    );

    assign bus_z.in_valid  = bus.in_valid;
    assign bus_z.in_dat    = bus.in_dat;
    assign bus_z.flush     = bus.flush;
    assign bus_z.full_soon = bus.full_soon;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            v;
        logic [LINE-1:0] d;
        logic            fl;
        logic            fs;
        logic            rdy;
        logic            we;
        logic [1:0]      cnt;
        logic [LINE-1:0] w1, w2, w3, w4;
        logic            idle;
    } vec_t;

    function automatic vec_t mk(logic v, logic [LINE-1:0] d, logic fl, logic fs,
                                logic rdy, logic we, logic [1:0] cnt,
                                logic [LINE-1:0] w1, logic [LINE-1:0] w2,
                                logic [LINE-1:0] w3, logic [LINE-1:0] w4,
                                logic idle);
        vec_t r;
        r.v = v; r.d = d; r.fl = fl; r.fs = fs; r.rdy = rdy; r.we = we;
        r.cnt = cnt; r.w1 = w1; r.w2 = w2; r.w3 = w3; r.w4 = w4; r.idle = idle;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle and let combinational in_ready settle.
    task automatic apply(input logic v, input logic [LINE-1:0] d, input logic fl, input logic fs);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_dat    = d;
        bus.flush     = fl;
        bus.full_soon = fs;
        #1;
    endtask

    // Cross one rising edge and sample registered outputs just after it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_line(input string name, input logic [1:0] cnt,
                              input logic [LINE-1:0] w1, input logic [LINE-1:0] w2,
                              input logic [LINE-1:0] w3, input logic [LINE-1:0] w4);
        check({name, ".we"},       32'(bus.we),       32'd1);
        check({name, ".we_count"}, 32'(bus.we_count), 32'(cnt));
        check({name, ".dat_w_1"},  32'(bus.dat_w_1),  32'(w1));
        check({name, ".dat_w_2"},  32'(bus.dat_w_2),  32'(w2));
        check({name, ".dat_w_3"},  32'(bus.dat_w_3),  32'(w3));
        check({name, ".dat_w_4"},  32'(bus.dat_w_4),  32'(w4));
    endtask

    vec_t tbl [17];

    initial begin
        int first_we;
        int we_pulses;
        int z_pulses;
        logic [1:0]      to_cnt;
        logic [LINE-1:0] to_w1;

        // Streaming 1..8, then a 2-element flush, then a flush with nothing held.
        tbl[0]  = mk(1, 1,   0, 0, 1, 0, 0, 0,   0,   0, 0, 0);
        tbl[1]  = mk(1, 2,   0, 0, 1, 0, 0, 0,   0,   0, 0, 0);
        tbl[2]  = mk(1, 3,   0, 0, 1, 0, 0, 0,   0,   0, 0, 0);
        tbl[3]  = mk(1, 4,   0, 0, 1, 0, 0, 0,   0,   0, 0, 0);
        tbl[4]  = mk(1, 5,   0, 0, 1, 1, 3, 1,   2,   3, 4, 0);
        tbl[5]  = mk(1, 6,   0, 0, 1, 0, 3, 1,   2,   3, 4, 0);
        tbl[6]  = mk(1, 7,   0, 0, 1, 0, 3, 1,   2,   3, 4, 0);
        tbl[7]  = mk(1, 8,   0, 0, 1, 0, 3, 1,   2,   3, 4, 0);
        tbl[8]  = mk(0, 0,   0, 0, 1, 1, 3, 5,   6,   7, 8, 0);
        tbl[9]  = mk(0, 0,   0, 0, 1, 0, 3, 5,   6,   7, 8, 1);
        tbl[10] = mk(1, 'hA, 0, 0, 1, 0, 3, 5,   6,   7, 8, 0);
        tbl[11] = mk(1, 'hB, 0, 0, 1, 0, 3, 5,   6,   7, 8, 0);
        tbl[12] = mk(0, 0,   1, 0, 1, 0, 3, 5,   6,   7, 8, 0);
        tbl[13] = mk(0, 0,   0, 0, 1, 1, 1, 'hA, 'hB, 0, 0, 0);
        tbl[14] = mk(0, 0,   0, 0, 1, 0, 1, 'hA, 'hB, 0, 0, 1);
        tbl[15] = mk(0, 0,   1, 0, 1, 0, 1, 'hA, 'hB, 0, 0, 1);
        tbl[16] = mk(0, 0,   0, 0, 1, 0, 1, 'hA, 'hB, 0, 0, 1);

        bus.in_valid  = 1'b0;
        bus.in_dat    = '0;
        bus.flush     = 1'b0;
        bus.full_soon = 1'b0;
        reset         = 1'b1;
        edge_step();
        edge_step();
        check("reset.we",       32'(bus.we),       32'd0);
        check("reset.we_count", 32'(bus.we_count), 32'd0);
        check("reset.dat_w",    32'(bus.dat_w_1 | bus.dat_w_2 | bus.dat_w_3 | bus.dat_w_4), 32'd0);
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.idle",     32'(bus.idle),     32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].fs);
            check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            edge_step();
            check($sformatf("vec%0d.we", i),       32'(bus.we),       32'(tbl[i].we));
            check($sformatf("vec%0d.we_count", i), 32'(bus.we_count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d.dat_w_1", i),  32'(bus.dat_w_1),  32'(tbl[i].w1));
            check($sformatf("vec%0d.dat_w_2", i),  32'(bus.dat_w_2),  32'(tbl[i].w2));
            check($sformatf("vec%0d.dat_w_3", i),  32'(bus.dat_w_3),  32'(tbl[i].w3));
            check($sformatf("vec%0d.dat_w_4", i),  32'(bus.dat_w_4),  32'(tbl[i].w4));
            check($sformatf("vec%0d.idle", i),     32'(bus.idle),     32'(tbl[i].idle));
        end

        // Timeout: one element at edge A, TIMEOUT=8 writes at edge A+9.
        apply(1, 'h55, 0, 0);
        edge_step();
        first_we  = 0;
        we_pulses = 0;
        z_pulses  = 0;
        to_cnt    = '1;
        to_w1     = '0;
        for (int k = 1; k <= 20; k++) begin
            apply(0, 0, 0, 0);
            edge_step();
            if (bus.we) begin
                we_pulses++;
                if (first_we == 0) begin
                    first_we = k;
                    to_cnt   = bus.we_count;
                    to_w1    = bus.dat_w_1;
                end
            end
            if (bus_z.we) z_pulses++;
        end
        check("timeout.edge",     32'(first_we),  32'd9);
        check("timeout.pulses",   32'(we_pulses), 32'd1);
        check("timeout.we_count", 32'(to_cnt),    32'd0);
        check("timeout.dat_w_1",  32'(to_w1),     32'h55);
        check("timeout0.pulses",  32'(z_pulses),  32'd0);
        check("timeout0.idle",    32'(bus_z.idle), 32'd0);
        apply(0, 0, 1, 0);
        edge_step();
        apply(0, 0, 0, 0);
        edge_step();
        check("timeout0.flush_we", 32'(bus_z.we),       32'd1);
        check("timeout0.dat_w_1",  32'(bus_z.dat_w_1),  32'h55);
        check("timeout.flush_empty_we", 32'(bus.we),    32'd0);
        edge_step();
        check("timeout0.idle_after", 32'(bus_z.idle),   32'd1);

        // Backpressure: fill under full_soon, hold 10 cycles, then release.
        for (int i = 0; i < 4; i++) begin
            apply(1, LINE'('h11 + i), 0, 1);
            check($sformatf("bp.fill%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
            edge_step();
            check($sformatf("bp.fill%0d.we", i), 32'(bus.we), 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            apply(1, 'h15, 0, 1);
            check($sformatf("bp.hold%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
            edge_step();
            check($sformatf("bp.hold%0d.we", i), 32'(bus.we), 32'd0);
        end
        apply(1, 'h15, 0, 0);
        check("bp.release.in_ready", 32'(bus.in_ready), 32'd1);
        edge_step();
        check_line("bp.release", 2'd3, 'h11, 'h12, 'h13, 'h14);
        apply(0, 0, 1, 0);
        edge_step();
        check("bp.gap.we", 32'(bus.we), 32'd0);
        apply(0, 0, 0, 0);
        edge_step();
        check_line("bp.slot0", 2'd0, 'h15, 0, 0, 0);

        // Flush on the same edge as the 4th accept: one full write only.
        for (int i = 0; i < 3; i++) begin
            apply(1, LINE'('h21 + i), 0, 0);
            edge_step();
        end
        apply(1, 'h24, 1, 0);
        edge_step();
        check("race.edge4.we", 32'(bus.we), 32'd0);
        apply(0, 0, 0, 0);
        edge_step();
        check_line("race", 2'd3, 'h21, 'h22, 'h23, 'h24);
        edge_step();
        check("race.after.we", 32'(bus.we), 32'd0);
        apply(1, 'h31, 0, 0);
        edge_step();
        we_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0);
            edge_step();
            if (bus.we) we_pulses++;
        end
        check("race.flush_cleared", 32'(we_pulses), 32'd0);
        apply(0, 0, 1, 0);
        edge_step();
        apply(0, 0, 0, 0);
        edge_step();
        check_line("race.next", 2'd0, 'h31, 0, 0, 0);

        // Reset with three elements held: discarded, no write afterwards.
        for (int i = 0; i < 3; i++) begin
            apply(1, LINE'('h41 + i), 0, 0);
            edge_step();
        end
        check("rst.held.idle", 32'(bus.idle), 32'd0);
        apply(0, 0, 0, 0);
        reset = 1'b1;
        edge_step();
        check("rst.we",       32'(bus.we),       32'd0);
        check("rst.idle",     32'(bus.idle),     32'd1);
        check("rst.we_count", 32'(bus.we_count), 32'd0);
        check("rst.dat_w_1",  32'(bus.dat_w_1),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        we_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            edge_step();
            if (bus.we) we_pulses++;
        end
        check("rst.no_write", 32'(we_pulses), 32'd0);
        check("rst.idle_end", 32'(bus.idle),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
